// File: rtl/gps_acq_scheduler.sv
// gps_acq_scheduler
//   Walks the enabled PRNs of a scan in ascending order. For each one it
//   launches a single correlator run, tracks the strongest bin reported by the
//   engine, and hands one result record to the CPU over a valid/ready pair.
//   The next PRN is launched only after the current record is accepted.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start, abort        scan launch pulse (IDLE only) / level that forces IDLE
//   prn_mask, threshold scan configuration, captured on start
//   busy, done          scan in progress / one-cycle end-of-scan pulse
//   acq_start, acq_prn  engine launch pulse and PRN select (1..32)
//   corr_*, code_*,     per-bin completion from the engine and its bin data
//   doppler
//   search_complete     engine end-of-run level
//   result_*            per-PRN record and its valid/ready handshake
module gps_acq_scheduler #(
  parameter int CORR_BITS      = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [31:0]                 prn_mask,
  input  logic [CORR_BITS-1:0]        threshold,
  output logic                        busy,
  output logic                        done,
  output logic                        acq_start,
  output logic [5:0]                  acq_prn,
  input  logic                        corr_complete,
  input  logic [CORR_BITS-1:0]        corr_value,
  input  logic [9:0]                  code_phase,
  input  logic [4:0]                  code_frac,
  input  logic signed [15:0]          doppler,
  input  logic                        search_complete,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [5:0]                  result_prn,
  output logic [CORR_BITS-1:0]        result_peak,
  output logic [9:0]                  result_phase,
  output logic [4:0]                  result_frac,
  output logic signed [15:0]          result_doppler,
  output logic                        result_detected,
  output logic                        result_timeout
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CORR_BITS-1:0] HALF = {1'b1, {(CORR_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FIND, S_LAUNCH, S_SEARCH, S_REPORT, S_FINISH
  } state_t;

  // Distance of the integrator from its mid-scale zero; 2^(CORR_BITS-1) still fits.
  function automatic logic [CORR_BITS-1:0] bin_metric(input logic [CORR_BITS-1:0] v);
    logic [CORR_BITS-1:0] m;
    if (v >= HALF) m = v - HALF;
    else           m = HALF - v;
    return m;
  endfunction

  function automatic logic [5:0] lowest_prn(input logic [31:0] m);
    logic [5:0] p;
    p = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) p = 6'(i + 1);
    end
    return p;
  endfunction

  state_t                      state_q, state_d;
  logic [31:0]                 pending_q, pending_d;
  logic [CORR_BITS-1:0]        thresh_q, thresh_d;
  logic [5:0]                  prn_q, prn_d;
  logic [4:0]                  prn_idx;
  logic [CORR_BITS-1:0]        best_q, best_d;
  logic [9:0]                  phase_q, phase_d;
  logic [4:0]                  frac_q, frac_d;
  logic signed [15:0]          dop_q, dop_d;
  logic [WD_W-1:0]             wdog_q, wdog_d;
  logic                        cc_prev_q, sc_prev_q;
  logic                        cc_edge, sc_edge;
  logic                        bin_vld_q, bin_vld_d;
  logic [CORR_BITS-1:0]        bin_met_q, bin_met_d;
  logic [9:0]                  bin_phase_q, bin_phase_d;
  logic [4:0]                  bin_frac_q, bin_frac_d;
  logic signed [15:0]          bin_dop_q, bin_dop_d;
  logic                        sc_pend_q, sc_pend_d;
  logic [CORR_BITS-1:0]        res_peak_q, res_peak_d;
  logic [9:0]                  res_phase_q, res_phase_d;
  logic [4:0]                  res_frac_q, res_frac_d;
  logic signed [15:0]          res_dop_q, res_dop_d;
  logic                        res_det_q, res_det_d;
  logic                        res_tmo_q, res_tmo_d;
  logic                        rep_go, rep_tmo;

  assign cc_edge = corr_complete & ~cc_prev_q;
  assign sc_edge = search_complete & ~sc_prev_q;
  assign prn_idx = 5'(prn_q - 6'd1);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    thresh_d    = thresh_q;
    prn_d       = prn_q;
    best_d      = best_q;
    phase_d     = phase_q;
    frac_d      = frac_q;
    dop_d       = dop_q;
    wdog_d      = wdog_q;
    bin_vld_d   = 1'b0;
    bin_met_d   = bin_met_q;
    bin_phase_d = bin_phase_q;
    bin_frac_d  = bin_frac_q;
    bin_dop_d   = bin_dop_q;
    sc_pend_d   = 1'b0;
    res_peak_d  = res_peak_q;
    res_phase_d = res_phase_q;
    res_frac_d  = res_frac_q;
    res_dop_d   = res_dop_q;
    res_det_d   = res_det_q;
    res_tmo_d   = res_tmo_q;
    rep_go      = 1'b0;
    rep_tmo     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d = prn_mask;
          thresh_d  = threshold;
          state_d   = S_FIND;
        end
      end
      S_FIND: begin
        if (pending_q == '0) begin
          state_d = S_FINISH;
        end else begin
          prn_d   = lowest_prn(pending_q);
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        best_d  = '0;
        phase_d = '0;
        frac_d  = '0;
        dop_d   = '0;
        wdog_d  = '0;
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        // p1: commit the bin captured on the previous edge; strict > keeps the earliest tie.
        if (bin_vld_q && (bin_met_q > best_q)) begin
          best_d  = bin_met_q;
          phase_d = bin_phase_q;
          frac_d  = bin_frac_q;
          dop_d   = bin_dop_q;
        end
        // p0: capture the bin at its corr_complete rising edge.
        if (cc_edge) begin
          bin_vld_d   = 1'b1;
          bin_met_d   = bin_metric(corr_value);
          bin_phase_d = code_phase;
          bin_frac_d  = code_frac;
          bin_dop_d   = doppler;
          wdog_d      = '0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
        // A run end arriving with a bin is deferred one cycle so that bin lands first.
        if (sc_pend_q) begin
          rep_go = 1'b1;
        end else if (sc_edge && cc_edge) begin
          sc_pend_d = 1'b1;
        end else if (sc_edge) begin
          rep_go = 1'b1;
        end else if (!cc_edge && (wdog_q == WD_LAST)) begin
          rep_go  = 1'b1;
          rep_tmo = 1'b1;
        end
        if (rep_go) begin
          state_d     = S_REPORT;
          res_peak_d  = best_d;
          res_phase_d = phase_d;
          res_frac_d  = frac_d;
          res_dop_d   = dop_d;
          res_tmo_d   = rep_tmo;
          res_det_d   = (best_d >= thresh_q) && !rep_tmo;
        end
      end
      S_REPORT: begin
        if (result_ready) begin
          pending_d[prn_idx] = 1'b0;
          state_d            = S_FIND;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      pending_d = '0;
      bin_vld_d = 1'b0;
      sc_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      thresh_q    <= '0;
      prn_q       <= '0;
      best_q      <= '0;
      phase_q     <= '0;
      frac_q      <= '0;
      dop_q       <= '0;
      wdog_q      <= '0;
      cc_prev_q   <= 1'b0;
      sc_prev_q   <= 1'b0;
      bin_vld_q   <= 1'b0;
      bin_met_q   <= '0;
      bin_phase_q <= '0;
      bin_frac_q  <= '0;
      bin_dop_q   <= '0;
      sc_pend_q   <= 1'b0;
      res_peak_q  <= '0;
      res_phase_q <= '0;
      res_frac_q  <= '0;
      res_dop_q   <= '0;
      res_det_q   <= 1'b0;
      res_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      thresh_q    <= thresh_d;
      prn_q       <= prn_d;
      best_q      <= best_d;
      phase_q     <= phase_d;
      frac_q      <= frac_d;
      dop_q       <= dop_d;
      wdog_q      <= wdog_d;
      cc_prev_q   <= corr_complete;
      sc_prev_q   <= search_complete;
      bin_vld_q   <= bin_vld_d;
      bin_met_q   <= bin_met_d;
      bin_phase_q <= bin_phase_d;
      bin_frac_q  <= bin_frac_d;
      bin_dop_q   <= bin_dop_d;
      sc_pend_q   <= sc_pend_d;
      res_peak_q  <= res_peak_d;
      res_phase_q <= res_phase_d;
      res_frac_q  <= res_frac_d;
      res_dop_q   <= res_dop_d;
      res_det_q   <= res_det_d;
      res_tmo_q   <= res_tmo_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_FINISH);
  assign acq_start       = (state_q == S_LAUNCH);
  assign acq_prn         = prn_q;
  assign result_valid    = (state_q == S_REPORT);
  assign result_prn      = prn_q;
  assign result_peak     = res_peak_q;
  assign result_phase    = res_phase_q;
  assign result_frac     = res_frac_q;
  assign result_doppler  = res_dop_q;
  assign result_detected = res_det_q;
  assign result_timeout  = res_tmo_q;

endmodule

// File: tb/tb_gps_acq_scheduler.sv
// Testbench for gps_acq_scheduler: drives an engine model and compares each
// result record against a reference computed from the bin lists it sends.
module tb_gps_acq_scheduler;
  localparam int CB   = 12;
  localparam int TMO  = 100;
  localparam int HALF = 2048;

  logic clk = 1'b0;
  logic rst, start, abort, corr_complete, search_complete, result_ready;
  logic [31:0] prn_mask;
  logic [CB-1:0] threshold, corr_value;
  logic [9:0] code_phase;
  logic [4:0] code_frac;
  logic [15:0] doppler;
  logic busy, done, acq_start, result_valid, result_detected, result_timeout;
  logic [5:0] acq_prn, result_prn;
  logic [CB-1:0] result_peak;
  logic [9:0] result_phase;
  logic [4:0] result_frac;
  logic [15:0] result_doppler;

  int total = 0, bad = 0;
  int acq_cnt = 0, overlap_cnt = 0, done_cnt = 0;
  int bv[$], bp[$], bf[$], bd[$];
  int exp_peak, exp_ph, exp_fr, exp_dp;

  always #5 clk = ~clk;

  gps_acq_scheduler #(.CORR_BITS(CB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prn_mask(prn_mask),
    .threshold(threshold), .busy(busy), .done(done), .acq_start(acq_start),
    .acq_prn(acq_prn), .corr_complete(corr_complete), .corr_value(corr_value),
    .code_phase(code_phase), .code_frac(code_frac), .doppler(doppler),
    .search_complete(search_complete), .result_valid(result_valid),
    .result_ready(result_ready), .result_prn(result_prn), .result_peak(result_peak),
    .result_phase(result_phase), .result_frac(result_frac),
    .result_doppler(result_doppler), .result_detected(result_detected),
    .result_timeout(result_timeout)
  );

  always @(negedge clk) begin
    if (acq_start) acq_cnt <= acq_cnt + 1;
    if (acq_start && result_valid) overlap_cnt <= overlap_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to end earlier", $time);
    $fatal(1, "global timeout");
  end

  function automatic logic [60:0] outs_vec();
    return {busy, done, acq_start, acq_prn, result_valid, result_prn, result_peak,
            result_phase, result_frac, result_doppler, result_detected, result_timeout};
  endfunction

  function automatic logic [50:0] rec_vec();
    return {result_prn, result_peak, result_phase, result_frac, result_doppler,
            result_detected, result_timeout};
  endfunction

  // Expected record: the strongest bin, detection only without a timeout.
  function automatic logic [50:0] exp_vec(input int prn, input int thr, input bit tmo);
    bit det;
    det = !tmo && (exp_peak >= thr);
    return {6'(prn), 12'(exp_peak), 10'(exp_ph), 5'(exp_fr), 16'(exp_dp), det, tmo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = acq_start, 1 = result_valid, 2 = done
  task automatic wait_for(input int which, input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit &&
           !((which == 0 && acq_start === 1'b1) || (which == 1 && result_valid === 1'b1) ||
             (which == 2 && done === 1'b1))) begin
      tick();
      cycles++;
    end
    total++;
    if (cycles >= limit) begin
      bad++;
      $display("FAIL wait_event%0d: not seen after %0d cycles, expected within %0d", which, cycles, limit);
    end
  endtask

  task automatic clear_bins();
    bv.delete(); bp.delete(); bf.delete(); bd.delete();
  endtask

  task automatic add_bin(input int v, input int p, input int f, input int d);
    bv.push_back(v); bp.push_back(p); bf.push_back(f); bd.push_back(d);
  endtask

  task automatic gen_bins(input int n, input int lo, input int hi);
    clear_bins();
    for (int i = 0; i < n; i++)
      add_bin($urandom_range(hi, lo), $urandom_range(1023, 0), $urandom_range(31, 0),
              $urandom_range(65535, 0));
  endtask

  task automatic model_best();
    int m;
    exp_peak = 0; exp_ph = 0; exp_fr = 0; exp_dp = 0;
    for (int i = 0; i < bv.size(); i++) begin
      m = (bv[i] >= HALF) ? bv[i] - HALF : HALF - bv[i];
      if (m > exp_peak) begin
        exp_peak = m; exp_ph = bp[i]; exp_fr = bf[i]; exp_dp = bd[i];
      end
    end
  endtask

  task automatic drive_run(input bit coincident);
    bit last;
    for (int i = 0; i < bv.size(); i++) begin
      last = (i == bv.size() - 1);
      corr_value = CB'(bv[i]); code_phase = 10'(bp[i]);
      code_frac = 5'(bf[i]); doppler = 16'(bd[i]);
      corr_complete = 1'b1;
      if (coincident && last) search_complete = 1'b1;
      tick();
      corr_complete = 1'b0; search_complete = 1'b0;
      corr_value = CB'($urandom);
      if (!(coincident && last)) repeat ($urandom_range(3, 1)) tick();
    end
    if (!coincident) begin
      search_complete = 1'b1;
      tick();
      search_complete = 1'b0;
    end
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic start_scan(input logic [31:0] m, input int thr);
    prn_mask = m; threshold = CB'(thr); start = 1'b1;
    tick();
    start = 1'b0; prn_mask = $urandom; threshold = CB'($urandom);
  endtask

  task automatic test_reset();
    total++;
    if (outs_vec() !== '0) begin bad++; $display("FAIL reset_hold: outputs=%h want 0", outs_vec()); end
    rst = 1'b0;
    tick();
    total++;
    if (outs_vec() !== '0) begin bad++; $display("FAIL reset_release: outputs=%h want 0", outs_vec()); end
  endtask

  task automatic test_single();
    int c, a0;
    a0 = acq_cnt;
    start_scan(32'h1, 300);
    wait_for(0, 10, c);
    total++; if (c !== 1) begin bad++; $display("FAIL start_to_acq: %0d want 1", c); end
    total++; if (acq_prn !== 6'd1) begin bad++; $display("FAIL single_acq_prn: %0d want 1", acq_prn); end
    tick();
    clear_bins();
    add_bin(2048, 10, 1, 100); add_bin(2500, 20, 2, 200); add_bin(1500, 30, 3, 32769);
    drive_run(1'b0);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL sc_to_valid: %b want 1", result_valid); end
    total++; if (result_peak !== 12'd548) begin bad++; $display("FAIL single_peak: %0d want 548", result_peak); end
    total++; if (result_phase !== 10'd30) begin bad++; $display("FAIL single_phase: %0d want 30", result_phase); end
    total++;
    if ({result_frac, result_doppler} !== {5'd3, 16'h8001}) begin
      bad++; $display("FAIL single_frac_dop: %0d/%h want 3/8001", result_frac, result_doppler);
    end
    total++;
    if ({result_prn, result_detected, result_timeout} !== {6'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_flags: prn=%0d det=%b tmo=%b want 1/1/0", result_prn, result_detected, result_timeout);
    end
    accept();
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL handshake_to_done: %b want 1", done); end
    total++; if (acq_cnt - a0 !== 1) begin bad++; $display("FAIL single_acq_count: %0d want 1", acq_cnt - a0); end
    tick();
  endtask

  task automatic test_multi();
    int c, a0, o0, nrec, thr;
    int exp_prn[$];
    logic [50:0] snap;
    bit stable;
    exp_prn.push_back(1); exp_prn.push_back(3); exp_prn.push_back(32);
    a0 = acq_cnt; o0 = overlap_cnt; nrec = 0; thr = $urandom_range(600, 0);
    start_scan(32'h8000_0005, thr);
    for (int k = 0; k < exp_prn.size(); k++) begin
      wait_for(0, 20, c);
      total++; if (c !== 1) begin bad++; $display("FAIL acq_latency: %0d want 1", c); end
      total++;
      if (acq_prn !== 6'(exp_prn[k])) begin bad++; $display("FAIL prn_order: %0d want %0d", acq_prn, exp_prn[k]); end
      tick();
      gen_bins($urandom_range(4, 1), 0, 4095);
      model_best();
      drive_run(1'b0);
      wait_for(1, 5, c);
      if (result_valid) nrec++;
      snap = rec_vec(); stable = 1'b1;
      repeat (20) begin
        tick();
        if (rec_vec() !== snap || result_valid !== 1'b1) stable = 1'b0;
      end
      total++; if (!stable) begin bad++; $display("FAIL stall_stable prn %0d: stable=%b want 1", exp_prn[k], stable); end
      total++;
      if (snap !== exp_vec(exp_prn[k], thr, 1'b0)) begin
        bad++; $display("FAIL multi_record: %h want %h", snap, exp_vec(exp_prn[k], thr, 1'b0));
      end
      accept();
    end
    wait_for(2, 10, c);
    total++; if (c !== 1) begin bad++; $display("FAIL last_hs_to_done: %0d want 1", c); end
    total++; if (nrec !== 3) begin bad++; $display("FAIL multi_records: %0d want 3", nrec); end
    total++; if (acq_cnt - a0 !== 3) begin bad++; $display("FAIL multi_acq_count: %0d want 3", acq_cnt - a0); end
    total++; if (overlap_cnt !== o0) begin bad++; $display("FAIL acq_during_valid: %0d want %0d", overlap_cnt, o0); end
    tick();
  endtask

  task automatic test_tie();
    int c;
    for (int thr = 300; thr <= 301; thr++) begin
      start_scan(32'h1, thr);
      wait_for(0, 10, c);
      tick();
      clear_bins();
      add_bin(2348, 5, 7, 11); add_bin(1748, 9, 8, 12);
      drive_run(1'b0);
      wait_for(1, 5, c);
      total++;
      if ({result_peak, result_phase} !== {12'd300, 10'd5}) begin
        bad++; $display("FAIL tie_keep_first: peak=%0d phase=%0d want 300/5", result_peak, result_phase);
      end
      total++;
      if (result_detected !== (thr == 300)) begin
        bad++; $display("FAIL threshold_edge thr=%0d: det=%b want %b", thr, result_detected, thr == 300);
      end
      accept();
      wait_for(2, 10, c);
      tick();
    end
  endtask

  task automatic test_coincident();
    int c, thr;
    thr = $urandom_range(4095, 0);
    start_scan(32'h1, thr);
    wait_for(0, 10, c);
    tick();
    gen_bins(3, 1, 4095);
    add_bin(0, 777, 17, 9999);
    model_best();
    drive_run(1'b1);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL coinc_early: %b want 0", result_valid); end
    tick();
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL coinc_late: %b want 1", result_valid); end
    total++; if (result_peak !== 12'd2048) begin bad++; $display("FAIL coinc_full_scale: %0d want 2048", result_peak); end
    total++;
    if (rec_vec() !== exp_vec(1, thr, 1'b0)) begin
      bad++; $display("FAIL coinc_record: %h want %h", rec_vec(), exp_vec(1, thr, 1'b0));
    end
    accept();
    wait_for(2, 10, c);
    tick();
  endtask

  task automatic test_watchdog();
    int c;
    start_scan(32'h3, 0);
    wait_for(0, 10, c);
    tick();
    wait_for(1, 300, c);
    total++; if (c !== TMO) begin bad++; $display("FAIL watchdog_cycles: %0d want %0d", c, TMO); end
    total++;
    if ({result_prn, result_timeout, result_detected} !== {6'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL watchdog_flags: prn=%0d tmo=%b det=%b want 1/1/0", result_prn, result_timeout, result_detected);
    end
    accept();
    wait_for(0, 10, c);
    total++; if (acq_prn !== 6'd2) begin bad++; $display("FAIL watchdog_next_prn: %0d want 2", acq_prn); end
    tick();
    gen_bins(2, 0, 4095);
    model_best();
    drive_run(1'b0);
    wait_for(1, 5, c);
    total++;
    if (rec_vec() !== exp_vec(2, 0, 1'b0)) begin
      bad++; $display("FAIL after_watchdog_record: %h want %h", rec_vec(), exp_vec(2, 0, 1'b0));
    end
    accept();
    wait_for(2, 10, c);
    tick();
  endtask

  task automatic test_empty();
    int c, a0;
    a0 = acq_cnt;
    start_scan(32'h0, 0);
    wait_for(2, 10, c);
    total++; if (c !== 1) begin bad++; $display("FAIL empty_done: %0d want 1", c); end
    total++; if (acq_cnt !== a0) begin bad++; $display("FAIL empty_acq: %0d want %0d", acq_cnt, a0); end
    tick();
  endtask

  task automatic test_abort();
    int c, d0, thr;
    thr = $urandom_range(600, 0);
    d0 = done_cnt;
    start_scan(32'h5, thr);
    wait_for(0, 10, c);
    tick();
    gen_bins(2, 0, 4095);
    drive_run(1'b0);
    wait_for(1, 5, c);
    accept();
    wait_for(0, 10, c);
    total++; if (acq_prn !== 6'd3) begin bad++; $display("FAIL abort_prn: %0d want 3", acq_prn); end
    tick();
    corr_value = CB'(100); corr_complete = 1'b1;
    tick();
    corr_complete = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, result_valid} !== 2'b00) begin bad++; $display("FAIL abort_idle: busy=%b valid=%b want 0/0", busy, result_valid); end
    repeat (5) tick();
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_no_done: %0d want %0d", done_cnt, d0); end
    start_scan(32'h5, thr);
    wait_for(0, 10, c);
    total++; if (acq_prn !== 6'd1) begin bad++; $display("FAIL restart_lowest: %0d want 1", acq_prn); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int c, thr;
    logic [31:0] m;
    int plist[$];
    for (int it = 0; it < 3; it++) begin
      m = $urandom;
      thr = $urandom_range(400, 0);
      plist.delete();
      for (int n = 0; n < 32; n++) if (m[n]) plist.push_back(n + 1);
      start_scan(m, thr);
      for (int k = 0; k < plist.size(); k++) begin
        wait_for(0, 10, c);
        total++;
        if (acq_prn !== 6'(plist[k])) begin bad++; $display("FAIL rand_prn: %0d want %0d", acq_prn, plist[k]); end
        tick();
        gen_bins($urandom_range(4, 0), 1800, 2300);
        model_best();
        drive_run(1'b0);
        wait_for(1, 5, c);
        total++;
        if (rec_vec() !== exp_vec(plist[k], thr, 1'b0)) begin
          bad++; $display("FAIL rand_record: %h want %h", rec_vec(), exp_vec(plist[k], thr, 1'b0));
        end
        repeat ($urandom_range(3, 0)) tick();
        accept();
      end
      wait_for(2, 10, c);
      total++; if (c !== 1) begin bad++; $display("FAIL rand_done: %0d want 1", c); end
      tick();
    end
  endtask

  task automatic test_rst_mid_report();
    int c;
    start_scan(32'h1, 0);
    wait_for(0, 10, c);
    tick();
    gen_bins(1, 0, 4095);
    drive_run(1'b0);
    wait_for(1, 5, c);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_report: %b want 1", result_valid); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs_vec() !== '0) begin bad++; $display("FAIL async_reset: outputs=%h want 0", outs_vec()); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; prn_mask = '0; threshold = '0;
    corr_complete = 1'b0; corr_value = '0; code_phase = '0; code_frac = '0;
    doppler = '0; search_complete = 1'b0; result_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    test_single();
    test_multi();
    test_tie();
    test_coincident();
    test_watchdog();
    test_empty();
    test_abort();
    test_random();
    test_rst_mid_report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_acq_scheduler.md
# gps_acq_scheduler

Sequences the GPS acquisition correlator across a list of PRNs. For each enabled PRN it:
- programs the PRN and launches one acquisition run;
- tracks the strongest correlation bin from the correlator's per-bin completion events;
- compares the peak against a threshold and returns one result record per PRN over a valid/ready handshake.

It sits between the receiver control CPU and the correlator engine, and it owns the engine's start and PRN-select inputs.

## Interface
Parameters:
- CORR_BITS, 12: width of the correlator integrator value; one run integrates 2^CORR_BITS samples.
- TIMEOUT_CYCLES, 65535: maximum clk cycles allowed in SEARCH without a bin completion or a search completion.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a scan; sampled only in IDLE.
- abort  in  1  level; forces IDLE on the next cycle from any state.
- prn_mask  in  32  bit n enables PRN n+1; captured on start.
- threshold  in  CORR_BITS  detection threshold on the metric; captured on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a scan finishes.
- acq_start  out  1  one-cycle launch pulse to the engine.
- acq_prn  out  6  PRN under test (1..32); held stable from LAUNCH through REPORT.
- corr_complete  in  1  engine level, high at the end of each bin.
- corr_value  in  CORR_BITS  engine integrator value; valid while corr_complete is high.
- code_phase  in  10  bin code phase from the engine.
- code_frac  in  5  bin code NCO fraction from the engine.
- doppler  in  16 signed  bin Doppler NCO word from the engine.
- search_complete  in  1  engine level, high when the run is done.
- result_valid  out  1  result record valid.
- result_ready  in  1  consumer accepts the record.
- result_prn  out  6  PRN of the record.
- result_peak  out  CORR_BITS  best metric.
- result_phase  out  10  code phase of the best bin.
- result_frac  out  5  code fraction of the best bin.
- result_doppler  out  16  Doppler word of the best bin.
- result_detected  out  1  result_peak >= threshold, and no timeout.
- result_timeout  out  1  the run was ended by the watchdog.

## Operation
States: IDLE, FIND, LAUNCH, SEARCH, REPORT, FINISH.
- IDLE:
  - on start, capture prn_mask into pending and capture threshold; go to FIND.
  - start with prn_mask==0 goes to FIND, then FINISH (done still pulses; no results).
- FIND:
  - if pending==0, go to FINISH;
  - otherwise acq_prn = index of the lowest set bit + 1; go to LAUNCH.
- LAUNCH:
  - acq_start=1 for this cycle only;
  - clear best, captured fields and the watchdog; go to SEARCH.
- SEARCH:
  - On a corr_complete rising edge (detected against the previous-cycle registered value):
    - metric = |corr_value − 2^(CORR_BITS−1)|, computed CORR_BITS wide; the maximum 2^(CORR_BITS−1) fits.
    - If metric > best (strictly greater), update best and capture code_phase, code_frac and doppler.
    - Ties keep the earliest bin.
  - On a search_complete rising edge, go to REPORT with timeout=0.
  - If both edges occur in the same cycle, the bin is evaluated first, then the state goes to REPORT.
  - The watchdog counts SEARCH cycles and resets on every corr_complete edge. When it reaches TIMEOUT_CYCLES, go to REPORT with timeout=1.
- REPORT:
  - result_valid=1; all fields are registered and stable until the handshake.
  - result_detected = (best >= threshold) && !timeout.
  - On result_valid && result_ready, clear the pending bit for acq_prn; go to FIND.
- FINISH: done=1 for one cycle; go to IDLE.
- abort:
  - highest priority; next state is IDLE.
  - result_valid drops and pending clears.
  - No done pulse is generated.
- The next PRN is never launched until the current record is accepted (backpressure stalls the scan).

## Timing
- Reset values:
  - state=IDLE; pending=0.
  - busy, done, acq_start, result_valid, result_detected and result_timeout are 0.
  - acq_prn=0; all result_* fields=0.
- Latency from start to the acq_start pulse of the first PRN: 2 cycles (start cycle→FIND→LAUNCH).
- corr_complete edge to best update: 2 cycles (1 for edge detection, 1 for the register write).
- search_complete edge to result_valid: 1 cycle. It is 2 when a bin edge occurs in the same cycle; the bin is never dropped.
- Handshake to next acq_start: 2 cycles (FIND, LAUNCH).
- Last handshake to done: 2 cycles (FIND, FINISH).
- start while busy is ignored.
- rst asserted mid-scan clears all state immediately and asynchronously.

## Test plan
- Single PRN:
  - stimulus: mask=0x1, threshold=300; engine model gives bins with values 2048, 2500, 1500 at phase 10/20/30.
  - required: acq_start once, acq_prn=1.
  - required record: peak=548 (the 1500 bin), phase=30, detected=1, timeout=0; then done.
- Multi-PRN ordering and backpressure:
  - stimulus: mask=0x8000_0005; result_ready held low for 20 cycles on each record.
  - required: records in PRN order 1, 3, 32, each held stable while stalled.
  - required: no acq_start while result_valid is high; exactly 3 records, then done.
- Tie and threshold boundary:
  - stimulus: two bins both with metric 300 at phases 5 and 9; threshold=300.
  - required: phase=5, detected=1.
  - repeat with threshold=301: detected=0.
- Watchdog:
  - stimulus: TIMEOUT_CYCLES=100; engine never completes.
  - required: REPORT after 100 SEARCH cycles with timeout=1, detected=0; scan continues to the next PRN.
- Abort and reset:
  - stimulus: abort during SEARCH of PRN 3.
  - required: IDLE next cycle, busy=0, no done pulse; a new start restarts from the lowest mask bit.
  - stimulus: rst mid-REPORT.
  - required: all outputs return to reset values asynchronously.
